// File: rtl/xgmii_rx_accum_if.sv
// XGMII receive beat bus plus the packed-word write bus toward the byte-reordering pre-FIFOs.
interface xgmii_rx_accum_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned CTRL_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = DATA_WIDTH / 4
);
    logic                  xgmii_valid;
    logic [IN_WIDTH-1:0]   xgmii_rxd;
    logic [IN_WIDTH/8-1:0] xgmii_rxc;
    logic                  br_wr_full;
    logic                  x_we;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CTRL_WIDTH+7:0] ctrl_out;

    modport master (
        output xgmii_valid, xgmii_rxd, xgmii_rxc, br_wr_full,
        input  x_we, data_out, ctrl_out
    );

    modport slave (
        input  xgmii_valid, xgmii_rxd, xgmii_rxc, br_wr_full,
        output x_we, data_out, ctrl_out
    );
endinterface

// File: rtl/xgmii_rx_accum.sv
// Packs four 64-bit XGMII beats into one 256-bit word with control/SOF field,
// skips all-idle words and discards whole frames when the downstream FIFO is full.
module xgmii_rx_accum #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned CTRL_WIDTH = 32,
    parameter int unsigned IN_WIDTH   = DATA_WIDTH / 4
) (
    input  logic            x_clk,
    input  logic            reset_,
    input  logic            fmac_rxd_en,
    input  logic            cnt_clr,
    xgmii_rx_accum_if.slave bus,
    output logic [31:0]     frame_drop_cnt,
    output logic            overflow
);
    localparam int unsigned BEAT_BYTES = IN_WIDTH / 8;
    localparam int unsigned ACC_W      = 3 * IN_WIDTH;
    localparam int unsigned ACC_C      = 3 * BEAT_BYTES;
    localparam logic [7:0]  CODE_S     = 8'hFB;
    localparam logic [7:0]  CODE_T     = 8'hFD;

    typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_DROP} state_t;

    state_t                state_q, state_d, cur_st;
    logic [1:0]            bidx_q, bidx_d;
    logic [ACC_W-1:0]      acc_data_q, acc_data_d;
    logic [ACC_C-1:0]      acc_ctrl_q, acc_ctrl_d;
    logic [7:0]            sof_q, sof_d, sof_w;
    logic                  active_q, active_d, act_w;
    logic                  drop_word_q, drop_word_d, drop_w;
    logic                  inc_drop;
    logic                  x_we_q, x_we_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CTRL_WIDTH+7:0] ctrl_out_q, ctrl_out_d;
    logic [31:0]           frame_drop_cnt_q, frame_drop_cnt_d;
    logic                  overflow_q, overflow_d;

    always_comb begin
        state_d     = state_q;
        bidx_d      = bidx_q;
        acc_data_d  = acc_data_q;
        acc_ctrl_d  = acc_ctrl_q;
        sof_d       = sof_q;
        active_d    = active_q;
        drop_word_d = drop_word_q;
        x_we_d      = 1'b0;
        data_out_d  = data_out_q;
        ctrl_out_d  = ctrl_out_q;
        overflow_d  = overflow_q;
        cur_st      = state_q;
        sof_w       = sof_q;
        act_w       = active_q;
        drop_w      = drop_word_q;
        inc_drop    = 1'b0;

        if (bus.xgmii_valid) begin
            // Whether a word is discarded is fixed by the state at its first beat.
            if (bidx_q == 2'd0) drop_w = (state_q == ST_DROP);
            if (state_q == ST_FRAME) act_w = 1'b1;

            for (int unsigned j = 0; j < BEAT_BYTES; j++) begin
                if (bus.xgmii_rxc[j]) begin
                    if (bus.xgmii_rxd[8*j +: 8] == CODE_T) begin
                        if (cur_st == ST_FRAME) act_w = 1'b1;
                        if (cur_st != ST_IDLE) cur_st = ST_IDLE;
                    end else if (bus.xgmii_rxd[8*j +: 8] == CODE_S &&
                                 cur_st == ST_IDLE && fmac_rxd_en) begin
                        cur_st = ST_FRAME;
                        act_w  = 1'b1;
                        if (j == 0) sof_w[{bidx_q, 1'b0}] = 1'b1;
                        else if (j == 4) sof_w[{bidx_q, 1'b1}] = 1'b1;
                    end
                end
            end

            // Beats shift in from the top so the three held beats land in order.
            acc_data_d  = {bus.xgmii_rxd, acc_data_q[ACC_W-1:IN_WIDTH]};
            acc_ctrl_d  = {bus.xgmii_rxc, acc_ctrl_q[ACC_C-1:BEAT_BYTES]};
            bidx_d      = bidx_q + 2'd1;
            state_d     = cur_st;
            sof_d       = sof_w;
            active_d    = act_w;
            drop_word_d = drop_w;

            if (bidx_q == 2'd3) begin
                sof_d       = '0;
                active_d    = 1'b0;
                drop_word_d = 1'b0;
                if (drop_w) begin
                    if (cur_st == ST_FRAME) begin
                        inc_drop = 1'b1;
                        state_d  = ST_DROP;
                    end
                end else if (act_w) begin
                    if (bus.br_wr_full) begin
                        inc_drop   = 1'b1;
                        overflow_d = 1'b1;
                        state_d    = (cur_st == ST_FRAME) ? ST_DROP : ST_IDLE;
                    end else begin
                        x_we_d     = 1'b1;
                        data_out_d = {bus.xgmii_rxd, acc_data_q};
                        ctrl_out_d = {sof_w, bus.xgmii_rxc, acc_ctrl_q};
                    end
                end
            end
        end

        frame_drop_cnt_d = frame_drop_cnt_q;
        if (cnt_clr) frame_drop_cnt_d = '0;
        else if (inc_drop && frame_drop_cnt_q != '1) frame_drop_cnt_d = frame_drop_cnt_q + 32'd1;
    end

    always_ff @(posedge x_clk or negedge reset_) begin
        if (!reset_) begin
            state_q          <= ST_IDLE;
            bidx_q           <= '0;
            acc_data_q       <= '0;
            acc_ctrl_q       <= '0;
            sof_q            <= '0;
            active_q         <= 1'b0;
            drop_word_q      <= 1'b0;
            x_we_q           <= 1'b0;
            data_out_q       <= '0;
            ctrl_out_q       <= '0;
            frame_drop_cnt_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            bidx_q           <= bidx_d;
            acc_data_q       <= acc_data_d;
            acc_ctrl_q       <= acc_ctrl_d;
            sof_q            <= sof_d;
            active_q         <= active_d;
            drop_word_q      <= drop_word_d;
            x_we_q           <= x_we_d;
            data_out_q       <= data_out_d;
            ctrl_out_q       <= ctrl_out_d;
            frame_drop_cnt_q <= frame_drop_cnt_d;
            overflow_q       <= overflow_d;
        end
    end

    assign bus.x_we       = x_we_q;
    assign bus.data_out   = data_out_q;
    assign bus.ctrl_out   = ctrl_out_q;
    assign frame_drop_cnt = frame_drop_cnt_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_xgmii_rx_accum.sv
// Directed self-checking bench for xgmii_rx_accum: packing, SOF markers, drops and counter.
module tb_xgmii_rx_accum;
    logic        x_clk       = 1'b0;
    logic        reset_      = 1'b0;
    logic        fmac_rxd_en = 1'b1;
    logic        cnt_clr     = 1'b0;
    logic [31:0] frame_drop_cnt;
    logic        overflow;

    xgmii_rx_accum_if bus ();

    xgmii_rx_accum dut (
        .x_clk          (x_clk),
        .reset_         (reset_),
        .fmac_rxd_en    (fmac_rxd_en),
        .cnt_clr        (cnt_clr),
        .bus            (bus),
        .frame_drop_cnt (frame_drop_cnt),
        .overflow       (overflow)
    );

    always #5 x_clk = ~x_clk;

    localparam logic [63:0] S_BEAT    = 64'hD5555555555555FB;
    localparam logic [63:0] T_BEAT    = 64'h07070707FDCCBBAA;
    localparam logic [63:0] IDLE_BEAT = 64'h0707070707070707;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] wq_data[$];
    logic [39:0]  wq_ctrl[$];

    always @(negedge x_clk) begin
        if (bus.x_we === 1'b1) begin
            wq_data.push_back(bus.data_out);
            wq_ctrl.push_back(bus.ctrl_out);
        end
    end

    function automatic logic [63:0] dpat(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {8{b}} ^ 64'h0123456789ABCDEF;
    endfunction

    // Beat n of the reference 16-beat frame: /S/ first, 14 data beats, /T/ at byte 3 last.
    function automatic logic [63:0] frame_beat(input int n);
        if (n == 0) return S_BEAT;
        if (n == 15) return T_BEAT;
        return dpat(n);
    endfunction

    function automatic logic [255:0] frame_word(input int w);
        return {frame_beat(4*w+3), frame_beat(4*w+2), frame_beat(4*w+1), frame_beat(4*w)};
    endfunction

    task automatic end_burst();
        @(negedge x_clk);
        bus.xgmii_valid = 1'b0;
        bus.br_wr_full  = 1'b0;
        cnt_clr         = 1'b0;
        fmac_rxd_en     = 1'b1;
        repeat (6) @(negedge x_clk);
        #1;
    endtask

    task automatic send_frame(input int full_word, input int clr_word, input int en_off_beat);
        for (int n = 0; n < 16; n++) begin
            @(negedge x_clk);
            bus.xgmii_valid = 1'b1;
            bus.xgmii_rxd   = frame_beat(n);
            bus.xgmii_rxc   = (n == 0) ? 8'h01 : (n == 15) ? 8'hF8 : 8'h00;
            bus.br_wr_full  = (n / 4 == full_word) && (n % 4 == 3);
            cnt_clr         = (n / 4 == clr_word) && (n % 4 == 3);
            fmac_rxd_en     = (n < en_off_beat);
        end
        end_burst();
    endtask

    task automatic send_idles(input int count);
        for (int n = 0; n < count; n++) begin
            @(negedge x_clk);
            bus.xgmii_valid = 1'b1;
            bus.xgmii_rxd   = IDLE_BEAT;
            bus.xgmii_rxc   = 8'hFF;
        end
        end_burst();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge x_clk);
        #1;
        n_checks++; if (bus.x_we !== 1'b0) begin n_fail++; $display("FAIL reset_x_we: got %b want 0", bus.x_we); end
        n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
        n_checks++; if (bus.ctrl_out !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", bus.ctrl_out); end
        n_checks++; if (frame_drop_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", frame_drop_cnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        @(negedge x_clk);
        reset_ = 1'b1;
        send_idles(4);
        n_checks++; if (wq_data.size() !== 0) begin n_fail++; $display("FAIL idle_writes: got %0d want 0", wq_data.size()); end
        n_checks++; if (bus.ctrl_out !== '0) begin n_fail++; $display("FAIL idle_ctrl: got %h want 0", bus.ctrl_out); end
    endtask

    task automatic test_frame();
        wq_data.delete(); wq_ctrl.delete();
        send_frame(-1, -1, 16);
        n_checks++; if (wq_data.size() !== 4) begin n_fail++; $display("FAIL frame_writes: got %0d want 4", wq_data.size()); end
        if (wq_data.size() == 4) begin
            n_checks++; if (wq_data[0] !== frame_word(0)) begin n_fail++; $display("FAIL frame_data0: got %h want %h", wq_data[0], frame_word(0)); end
            n_checks++; if (wq_ctrl[0] !== 40'h0100000001) begin n_fail++; $display("FAIL frame_ctrl0: got %h want 0100000001", wq_ctrl[0]); end
            n_checks++; if (wq_data[3] !== frame_word(3)) begin n_fail++; $display("FAIL frame_data3: got %h want %h", wq_data[3], frame_word(3)); end
            n_checks++; if (wq_ctrl[3] !== 40'h00F8000000) begin n_fail++; $display("FAIL frame_ctrl3: got %h want 00F8000000", wq_ctrl[3]); end
        end
        n_checks++; if (bus.data_out !== frame_word(3)) begin n_fail++; $display("FAIL frame_hold: got %h want %h", bus.data_out, frame_word(3)); end
        send_idles(4);
        n_checks++; if (wq_data.size() !== 4) begin n_fail++; $display("FAIL frame_back_idle: got %0d want 4", wq_data.size()); end
    endtask

    task automatic test_sof_byte4();
        logic [63:0] d [8];
        logic [7:0]  c [8];
        d = '{IDLE_BEAT, IDLE_BEAT, 64'h555555FB07070707, dpat(20), dpat(21), dpat(22), dpat(23), 64'h07070707070707FD};
        c = '{8'hFF, 8'hFF, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        wq_data.delete(); wq_ctrl.delete();
        for (int n = 0; n < 8; n++) begin
            @(negedge x_clk);
            bus.xgmii_valid = 1'b1;
            bus.xgmii_rxd   = d[n];
            bus.xgmii_rxc   = c[n];
        end
        end_burst();
        n_checks++; if (wq_data.size() !== 2) begin n_fail++; $display("FAIL sof4_writes: got %0d want 2", wq_data.size()); end
        if (wq_data.size() == 2) begin
            n_checks++; if (wq_ctrl[0] !== 40'h20001FFFFF) begin n_fail++; $display("FAIL sof4_ctrl0: got %h want 20001FFFFF", wq_ctrl[0]); end
            n_checks++; if (wq_data[0] !== {dpat(20), 64'h555555FB07070707, IDLE_BEAT, IDLE_BEAT}) begin
                n_fail++; $display("FAIL sof4_data0: got %h", wq_data[0]); end
            n_checks++; if (wq_ctrl[1] !== 40'h00FF000000) begin n_fail++; $display("FAIL sof4_ctrl1: got %h want 00FF000000", wq_ctrl[1]); end
        end
    endtask

    task automatic test_overflow();
        wq_data.delete(); wq_ctrl.delete();
        send_frame(1, -1, 16);
        n_checks++; if (wq_data.size() !== 1) begin n_fail++; $display("FAIL ovf_writes: got %0d want 1", wq_data.size()); end
        if (wq_data.size() == 1) begin
            n_checks++; if (wq_ctrl[0] !== 40'h0100000001) begin n_fail++; $display("FAIL ovf_ctrl0: got %h want 0100000001", wq_ctrl[0]); end
        end
        n_checks++; if (frame_drop_cnt !== 32'd1) begin n_fail++; $display("FAIL ovf_cnt: got %h want 1", frame_drop_cnt); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        wq_data.delete(); wq_ctrl.delete();
        send_frame(-1, -1, 16);
        n_checks++; if (wq_data.size() !== 4) begin n_fail++; $display("FAIL ovf_next_writes: got %0d want 4", wq_data.size()); end
        n_checks++; if (frame_drop_cnt !== 32'd1) begin n_fail++; $display("FAIL ovf_next_cnt: got %h want 1", frame_drop_cnt); end
    endtask

    task automatic test_rxd_en();
        wq_data.delete(); wq_ctrl.delete();
        send_frame(-1, -1, 0);
        n_checks++; if (wq_data.size() !== 0) begin n_fail++; $display("FAIL en_off_writes: got %0d want 0", wq_data.size()); end
        wq_data.delete(); wq_ctrl.delete();
        send_frame(-1, -1, 2);
        n_checks++; if (wq_data.size() !== 4) begin n_fail++; $display("FAIL en_fall_writes: got %0d want 4", wq_data.size()); end
        if (wq_data.size() == 4) begin
            n_checks++; if (wq_ctrl[3] !== 40'h00F8000000) begin n_fail++; $display("FAIL en_fall_ctrl3: got %h want 00F8000000", wq_ctrl[3]); end
        end
    endtask

    task automatic test_counter();
        @(negedge x_clk);
        force dut.frame_drop_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.frame_drop_cnt_q;
        send_frame(1, -1, 16);
        n_checks++; if (frame_drop_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt_saturate: got %h want ffffffff", frame_drop_cnt); end
        send_frame(1, 1, 16);
        n_checks++; if (frame_drop_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_clr_wins: got %h want 0", frame_drop_cnt); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL cnt_ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_reset_midword();
        @(negedge x_clk);
        bus.xgmii_valid = 1'b1; bus.xgmii_rxd = S_BEAT; bus.xgmii_rxc = 8'h01;
        @(negedge x_clk);
        bus.xgmii_rxd = dpat(1); bus.xgmii_rxc = 8'h00;
        #2;
        reset_ = 1'b0;
        #1;
        n_checks++; if (bus.x_we !== 1'b0) begin n_fail++; $display("FAIL arst_x_we: got %b want 0", bus.x_we); end
        n_checks++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL arst_data: got %h want 0", bus.data_out); end
        n_checks++; if (bus.ctrl_out !== '0) begin n_fail++; $display("FAIL arst_ctrl: got %h want 0", bus.ctrl_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_ovf: got %b want 0", overflow); end
        n_checks++; if (frame_drop_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_cnt: got %h want 0", frame_drop_cnt); end
        bus.xgmii_valid = 1'b0;
        @(negedge x_clk);
        reset_ = 1'b1;
        wq_data.delete(); wq_ctrl.delete();
        send_frame(-1, -1, 16);
        n_checks++; if (wq_data.size() !== 4) begin n_fail++; $display("FAIL arst_writes: got %0d want 4", wq_data.size()); end
        if (wq_data.size() == 4) begin
            n_checks++; if (wq_data[0] !== frame_word(0)) begin n_fail++; $display("FAIL arst_align: got %h want %h", wq_data[0], frame_word(0)); end
        end
        n_checks++; if (frame_drop_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_cnt_after: got %h want 0", frame_drop_cnt); end
    endtask

    initial begin
        bus.xgmii_valid = 1'b0;
        bus.xgmii_rxd   = '0;
        bus.xgmii_rxc   = '0;
        bus.br_wr_full  = 1'b0;
        test_reset();
        test_frame();
        test_sof_byte4();
        test_overflow();
        test_rxd_en();
        test_counter();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
